// File: rtl/pulse_train_ctrl.sv
// rtl/pulse_train_ctrl.sv - BIST pulse-train stimulus controller with runtime high/low/count config.
// Optional continuous mode is enabled by defining PULSE_TRAIN_CONT_EN (adds the cont input).
module pulse_train_ctrl #(
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 8,
  parameter int DEF_HIGH   = 8,
  parameter int DEF_LOW    = 1,
  parameter int DEF_PULSES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [CNT_W-1:0] num_pulses,
`ifdef PULSE_TRAIN_CONT_EN
  input  logic             cont,
`endif
  output logic             out,
  output logic             running,
  output logic             bist_end,
  output logic [CNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_H = 2'd1,
    RUN_L = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic [LEN_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [LEN_W-1:0] high_len_q, high_len_d;
  logic [LEN_W-1:0] low_len_q, low_len_d;
  logic [CNT_W-1:0] num_pulses_q, num_pulses_d;
`ifdef PULSE_TRAIN_CONT_EN
  logic             cont_q, cont_d;
`endif

  logic             launch;
  logic             last_high;
  logic             last_low;
  logic [CNT_W-1:0] cnt_inc;

  assign launch    = start & ~start_q;
  // Latched lengths are never zero (clamped at launch), so length-1 cannot underflow.
  assign last_high = (phase_q == (high_len_q - LEN_W'(1)));
  assign last_low  = (phase_q == (low_len_q - LEN_W'(1)));
  assign cnt_inc   = pulse_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    start_d      = start;
    phase_d      = phase_q;
    pulse_cnt_d  = pulse_cnt_q;
    high_len_d   = high_len_q;
    low_len_d    = low_len_q;
    num_pulses_d = num_pulses_q;
`ifdef PULSE_TRAIN_CONT_EN
    cont_d       = cont_q;
`endif

    if (abort) begin
      state_d = IDLE;
      phase_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (launch) begin
            high_len_d   = (high_len == '0) ? LEN_W'(1) : high_len;
            low_len_d    = (low_len == '0) ? LEN_W'(1) : low_len;
            num_pulses_d = num_pulses;
`ifdef PULSE_TRAIN_CONT_EN
            cont_d       = cont;
`endif
            pulse_cnt_d  = '0;
            phase_d      = '0;
            state_d      = (num_pulses == '0) ? DONE : RUN_H;
          end
        end
        RUN_H: begin
          if (last_high) begin
            phase_d     = '0;
            pulse_cnt_d = cnt_inc;
            if (cnt_inc == num_pulses_q) begin
`ifdef PULSE_TRAIN_CONT_EN
              if (cont_q) begin
                state_d     = RUN_L;
                pulse_cnt_d = '0;
              end else begin
                state_d = DONE;
              end
`else
              state_d = DONE;
`endif
            end else begin
              state_d = RUN_L;
            end
          end else begin
            phase_d = phase_q + LEN_W'(1);
          end
        end
        RUN_L: begin
          if (last_low) begin
            phase_d = '0;
            state_d = RUN_H;
          end else begin
            phase_d = phase_q + LEN_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      phase_q      <= '0;
      pulse_cnt_q  <= '0;
      high_len_q   <= LEN_W'(DEF_HIGH);
      low_len_q    <= LEN_W'(DEF_LOW);
      num_pulses_q <= CNT_W'(DEF_PULSES);
`ifdef PULSE_TRAIN_CONT_EN
      cont_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      phase_q      <= phase_d;
      pulse_cnt_q  <= pulse_cnt_d;
      high_len_q   <= high_len_d;
      low_len_q    <= low_len_d;
      num_pulses_q <= num_pulses_d;
`ifdef PULSE_TRAIN_CONT_EN
      cont_q       <= cont_d;
`endif
    end
  end

  assign out       = (state_q == RUN_H);
  assign running   = (state_q == RUN_H) || (state_q == RUN_L);
  assign bist_end  = (state_q == DONE);
  assign pulse_cnt = pulse_cnt_q;

endmodule
